// File: rtl/credit_pkg.sv
// Shared constants and helpers for the credit-link receiver.
//   CREDIT_DEPTH_DEFAULT : default buffer depth (equals the sender's initial credits)
//   clog2()              : ceil-log2, sizes pointers and occupancy counters
package credit_pkg;

  localparam int unsigned CREDIT_DEPTH_DEFAULT = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << result) < 64'(value)) result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/credit_rx_fifo.sv
// Show-ahead FIFO holding flits received over the credit link.
// Ports:
//   clock, resetn : clock and synchronous active-low reset (pointers/occupancy only)
//   push, push_data : write push_data at the tail; dropped when full without a pop
//   pop            : remove the head entry (ignored when empty)
//   head_data      : head entry, combinational from storage
//   count          : occupancy, log2(DEPTH)+1 bits
//   full           : count == DEPTH
module credit_rx_fifo
  import credit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = CREDIT_DEPTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [clog2(DEPTH):0] count,
  output logic                  full
);

  localparam int unsigned PtrW = clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign full      = (count_q == CntW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/credit_receiver.sv
// Receiving endpoint of a credit-based link: buffers flits and returns one credit
// (a single-cycle o_increment_count pulse, registered) per flit taken by the pearl.
// Optional feature macro: CREDIT_RECEIVER_OVERFLOW_CHECK_EN enables the sticky
// o_overflow flag and a simulation assertion; otherwise o_overflow is tied to 0.
// Ports:
//   clock, resetn      : clock and synchronous active-low reset
//   i_data, i_valid    : flit from the link (no backpressure)
//   o_data, o_valid    : head flit to the pearl (show-ahead)
//   i_ready            : pearl accepts the head flit
//   o_increment_count  : credit return, one pulse per credit
//   o_overflow         : sticky push-while-full error
module credit_receiver
  import credit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 0,
  parameter int unsigned CREDIT_DEPTH = CREDIT_DEPTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_increment_count,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overflow
);

  logic [clog2(CREDIT_DEPTH):0] count;
  logic                         full;
  logic                         pop;
  logic                         inc_q;

  credit_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (CREDIT_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (i_valid),
    .push_data (i_data),
    .pop       (pop),
    .head_data (o_data),
    .count     (count),
    .full      (full)
  );

  assign o_valid = (count != '0);
  assign pop     = o_valid && i_ready;

  // Each pop returns its credit on the following cycle; pops never coalesce.
  always_ff @(posedge clock) begin
    if (!resetn) inc_q <= 1'b0;
    else         inc_q <= pop;
  end
  assign o_increment_count = inc_q;

`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  logic overflow_q;
  logic overflow_event;

  assign overflow_event = i_valid && full && !pop;

  always_ff @(posedge clock) begin
    if (!resetn)             overflow_q <= 1'b0;
    else if (overflow_event) overflow_q <= 1'b1;
  end
  assign o_overflow = overflow_q;

  overflow_chk : assert property (@(posedge clock) disable iff (!resetn) !overflow_event)
    else $warning("credit_receiver: flit pushed while full, dropped");
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_credit_receiver.sv
module tb_credit_receiver;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clock;
  logic          resetn;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_increment_count;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_overflow;

  credit_receiver #(
    .DATA_WIDTH   (DW),
    .CREDIT_DEPTH (DEPTH)
  ) dut (
    .clock             (clock),
    .resetn            (resetn),
    .i_data            (i_data),
    .i_valid           (i_valid),
    .o_increment_count (o_increment_count),
    .o_data            (o_data),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_overflow        (o_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  int pops_seen   = 0;
  int pulses_seen = 0;
  logic prev_pop  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on every accepted head flit and
  // expects the credit pulse exactly one cycle after each pop.
  always @(negedge clock) begin
    check("credit_pulse", {31'd0, o_increment_count}, {31'd0, prev_pop});
    if (o_increment_count) pulses_seen++;
    if (resetn && o_valid && i_ready) begin
      pops_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        check("pop_data", {24'd0, o_data}, {24'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
      prev_pop = 1'b1;
    end else begin
      prev_pop = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one flit for one cycle; kept=0 means the DUT must drop it.
  task automatic push_flit(input logic [DW-1:0] d, input bit kept);
    i_valid = 1'b1;
    i_data  = d;
    if (kept) exp_q.push_back(d);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    i_ready = 1'b0;
    check("drain_done_left", exp_q.size(), 0);
    check("drain_o_valid", {31'd0, o_valid}, 0);
    tick();
  endtask

  initial begin
    int credits;
    resetn  = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    tick();
    tick();
    check("rst_o_valid", {31'd0, o_valid}, 0);
    check("rst_inc", {31'd0, o_increment_count}, 0);
    check("rst_ovf", {31'd0, o_overflow}, 0);
    resetn = 1'b1;
    tick();

    // Three pushes, pearl stalled.
    push_flit(8'h11, 1);
    check("first_visible", {31'd0, o_valid}, 1);
    check("first_data", {24'd0, o_data}, 32'h11);
    push_flit(8'h22, 1);
    push_flit(8'h33, 1);
    check("stall_o_valid", {31'd0, o_valid}, 1);
    check("stall_head", {24'd0, o_data}, 32'h11);
    check("stall_inc", {31'd0, o_increment_count}, 0);

    // Three pops back to back.
    i_ready = 1'b1;
    tick();
    tick();
    tick();
    i_ready = 1'b0;
    check("after_pops_valid", {31'd0, o_valid}, 0);
    check("last_pulse", {31'd0, o_increment_count}, 1);
    tick();
    check("pulses_done", {31'd0, o_increment_count}, 0);

    // Full, then simultaneous push and pop.
    push_flit(8'hA1, 1);
    push_flit(8'hA2, 1);
    push_flit(8'hA3, 1);
    push_flit(8'hA4, 1);
    i_ready = 1'b1;
    push_flit(8'hAA, 1);
    i_ready = 1'b0;
    check("full_pushpop_valid", {31'd0, o_valid}, 1);
    check("full_pushpop_head", {24'd0, o_data}, 32'hA2);
    check("full_pushpop_ovf", {31'd0, o_overflow}, 0);
    drain();

    // Full, then a fifth push with no pop: dropped.
    push_flit(8'hB1, 1);
    push_flit(8'hB2, 1);
    push_flit(8'hB3, 1);
    push_flit(8'hB4, 1);
    push_flit(8'hEE, 0);
    check("ovf_set", {31'd0, o_overflow}, {31'd0, OVF_EXP});
    tick();
    tick();
    check("ovf_sticky", {31'd0, o_overflow}, {31'd0, OVF_EXP});
    check("ovf_head_intact", {24'd0, o_data}, 32'hB1);
    drain();
    check("ovf_after_drain", {31'd0, o_overflow}, {31'd0, OVF_EXP});

    // Reset while two entries are held.
    push_flit(8'hC1, 1);
    push_flit(8'hC2, 1);
    resetn = 1'b0;
    exp_q.delete();
    tick();
    resetn = 1'b1;
    check("midrst_valid", {31'd0, o_valid}, 0);
    check("midrst_inc", {31'd0, o_increment_count}, 0);
    check("midrst_ovf", {31'd0, o_overflow}, 0);
    tick();
    check("midrst_still_empty", {31'd0, o_valid}, 0);
    push_flit(8'hD1, 1);
    push_flit(8'hD2, 1);
    check("no_stale_head", {24'd0, o_data}, 32'hD1);
    drain();

    // Random traffic from a model sender holding DEPTH credits.
    credits = DEPTH;
    for (int c = 0; c < 10000; c++) begin
      if (o_increment_count) credits++;
      i_ready = 1'(($urandom % 3) != 0);
      if (credits > 0 && ($urandom % 2) == 1) begin
        credits--;
        i_valid = 1'b1;
        i_data  = DW'($urandom);
        exp_q.push_back(i_data);
      end else begin
        i_valid = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    i_valid = 1'b0;
    drain();
    tick();
    check("rand_ovf", {31'd0, o_overflow}, 0);
    check("pulses_eq_pops", pulses_seen, pops_seen);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/credit_receiver.md
CREDIT_RECEIVER -- requirements
Module: credit_receiver

Interface
REQ-001 Parameter: DATA_WIDTH, default 0, data bits per flit; must be set to 1 or more by the instantiator.
REQ-002 Parameter: CREDIT_DEPTH, default 4, buffer entries (equal to the credits the sender starts with); power of two, 2 or more.
REQ-003 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: resetn  input  1  reset, synchronous, active-low.
REQ-005 Port: i_data  input  DATA_WIDTH  flit from link side.
REQ-006 Port: i_valid  input  1  flit present on link side this cycle.
REQ-007 Port: o_increment_count  output  1  credit return to sender; one pulse = one credit.
REQ-008 Port: o_data  output  DATA_WIDTH  head flit to pearl.
REQ-009 Port: o_valid  output  1  head flit valid to pearl.
REQ-010 Port: i_ready  input  1  pearl accepts head flit.
REQ-011 Port: o_overflow  output  1  sticky overflow error flag (see Configuration).

Function
REQ-012 The block is the receiving endpoint of the credit link: it buffers flits and returns exactly one credit per flit consumed by the pearl.
REQ-013 Push: i_valid=1 writes i_data into the FIFO tail at the clock edge; there is no backpressure to the link side.
REQ-014 Pop: o_valid && i_ready removes the head entry at the clock edge.
REQ-015 o_valid = (occupancy != 0); o_data = head entry, show-ahead, combinational from storage; o_data is don't-care when o_valid=0.
REQ-016 Latency: a flit pushed at edge N is visible on o_valid/o_data after edge N (0 cycles if the FIFO was empty).
REQ-017 o_increment_count is registered: pop at edge N gives o_increment_count=1 for the cycle after edge N only.
REQ-018 Back-to-back pops give one pulse per cycle; credits returned always equal pops, with none coalesced or dropped.
REQ-019 Occupancy counter is log2(CREDIT_DEPTH)+1 bits wide; read and write pointers are log2(CREDIT_DEPTH) bits and wrap modulo CREDIT_DEPTH.
REQ-020 Simultaneous push and pop: occupancy is unchanged, the old head is popped, and the new flit is written, including when full.
REQ-021 Push when full with no pop is a protocol violation: the flit is dropped, pointers and occupancy are unchanged, and overflow handling follows REQ-026/027.
REQ-022 Pop when empty cannot occur, because o_valid=0.

Reset
REQ-023 With resetn=0 at an edge: pointers=0, occupancy=0, o_increment_count=0, o_overflow=0; o_valid therefore reads 0.
REQ-024 Reset mid-operation discards buffered flits and does not return credits for them; the sender is reset in the same cycle.
REQ-025 Storage contents are not reset.

Configuration
REQ-026 Macro CREDIT_RECEIVER_OVERFLOW_CHECK_EN defined: o_overflow sets on a REQ-021 event and holds until reset; a simulation-only assertion also fires.
REQ-027 Macro not defined: o_overflow is tied to 0, no overflow logic or assertion is generated, and a dropped flit is otherwise identical.

Structure
REQ-028 Shared package credit_pkg holds the CREDIT_DEPTH default constant and a ceil-log2 function used for pointer and occupancy widths.
REQ-029 Storage and pointers go in one sub-module credit_rx_fifo (push, pop, head data, occupancy); credit_receiver adds credit-return and overflow logic.

Verification
REQ-030 Reset, then 3 pushes (0x11, 0x22, 0x33) with i_ready=0: o_valid=1, o_data=0x11, o_increment_count stays 0.
REQ-031 Then i_ready=1 for 3 cycles: o_data sequence 0x11, 0x22, 0x33; 3 single-cycle increment pulses, each one cycle after its pop; o_valid=0 afterward.
REQ-032 CREDIT_DEPTH=4: fill to 4, then push 0xAA and pop in the same cycle: occupancy stays 4, o_overflow=0, and 0xAA is the last flit drained.
REQ-033 Full and a 5th push with no pop, macro defined: o_overflow=1 and sticky, flit dropped, 4 original flits drain intact; macro undefined: o_overflow=0.
REQ-034 Random push/pop over 10,000 cycles with a model sender holding 4 credits: no overflow, data order preserved, total pulses = total pops.
REQ-035 resetn=0 while 2 entries are held: next cycle o_valid=0 and o_increment_count=0, and no stale data appears after new pushes.
